// File: rtl/mem_arbiter_ctrl.sv
// Two-requester memory arbiter: fetch (read-only) and load/store share one
// word-addressed ROM/RAM bus, one access at a time, with a bounded MFC wait.
module mem_arbiter_ctrl #(
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_LS_STREAK  = 4,
  parameter int unsigned ADDR_LIMIT     = 127,
  parameter int unsigned ROM_TOP        = 63
) (
  input  logic        MEMARB_Clock,
  input  logic        MEMARB_Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Address,
  output logic        IF_Ack,
  output logic [31:0] IF_Data,
  output logic        IF_Error,
  input  logic        LS_Req,
  input  logic        LS_Write,
  input  logic [31:0] LS_Address,
  input  logic [31:0] LS_Data_In,
  output logic        LS_Ack,
  output logic [31:0] LS_Data,
  output logic        LS_Error,
  output logic [31:0] MEM_Address,
  output logic [31:0] MEM_Data_In,
  output logic [1:0]  MEM_r_w_z_z,
  input  logic [31:0] MEM_Data_Out,
  input  logic        MEM_MFC,
  input  logic        MEM_ERROR,
  output logic        MEMARB_Busy,
  output logic        MEMARB_Grant_LS
);

  // state  | meaning
  // IDLE   | bus released, arbitrate and pre-check the winner
  // ACCESS | bus driven, timer running, waiting for MFC
  // DONE   | bus released, one-cycle ack to the granted requester

  localparam int unsigned TMR_SPAN = ACCESS_CYCLES + TIMEOUT_CYCLES;
  localparam int unsigned TMR_W    = $clog2(TMR_SPAN);
  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);

  // Down-counter: remaining = TMR_SPAN - access_count, so the MFC window
  // opens at TIMEOUT_CYCLES and terminal count 0 is the timeout.
  localparam logic [TMR_W-1:0]    TMR_LOAD   = TMR_W'(TMR_SPAN - 1);
  localparam logic [TMR_W-1:0]    TMR_WIN    = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [31:0]         ADDR_LIM   = 32'(ADDR_LIMIT);
  localparam logic [31:0]         ROM_LIM    = 32'(ROM_TOP);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant_ls_q, grant_ls_d;
  logic                wr_q, wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                pick_ls;
  logic                sel_wr;
  logic [31:0]         sel_addr;
  logic                pre_err;

  always_ff @(posedge MEMARB_Clock) begin
    if (MEMARB_Reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      streak_q   <= '0;
      grant_ls_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      streak_q   <= streak_d;
      grant_ls_q <= grant_ls_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    streak_d   = streak_q;
    grant_ls_d = grant_ls_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    IF_Ack      = 1'b0;
    IF_Data     = '0;
    IF_Error    = 1'b0;
    LS_Ack      = 1'b0;
    LS_Data     = '0;
    LS_Error    = 1'b0;
    MEM_r_w_z_z = 2'b10;

    // LS has priority until it has starved a waiting fetch MAX_LS_STREAK times.
    pick_ls  = LS_Req && !(IF_Req && (streak_q == STREAK_MAX));
    sel_addr = pick_ls ? LS_Address : IF_Address;
    sel_wr   = pick_ls && LS_Write;
    pre_err  = (sel_addr > ADDR_LIM) || (sel_wr && (sel_addr <= ROM_LIM));

    case (state_q)
      S_IDLE: begin
        if (IF_Req || LS_Req) begin
          grant_ls_d = pick_ls;
          wr_d       = sel_wr;
          addr_d     = sel_addr;
          wdata_d    = pick_ls ? LS_Data_In : 32'h0;
          streak_d   = (pick_ls && IF_Req) ? streak_q + STREAK_W'(1) : '0;
          rdata_d    = '0;
          err_d      = pre_err;
          if (pre_err) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCESS;
            tmr_d   = TMR_LOAD;
          end
        end
      end
      S_ACCESS: begin
        MEM_r_w_z_z = wr_q ? 2'b01 : 2'b00;
        if ((tmr_q <= TMR_WIN) && MEM_MFC) begin
          rdata_d = wr_q ? 32'h0 : MEM_Data_Out;
          err_d   = MEM_ERROR;
          tmr_d   = '0;
          state_d = S_DONE;
        end else if (tmr_q == '0) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        if (grant_ls_q) begin
          LS_Ack   = 1'b1;
          LS_Data  = rdata_q;
          LS_Error = err_q;
        end else begin
          IF_Ack   = 1'b1;
          IF_Data  = rdata_q;
          IF_Error = err_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_Address     = addr_q;
  assign MEM_Data_In     = wdata_q;
  assign MEMARB_Busy     = (state_q != S_IDLE);
  assign MEMARB_Grant_LS = grant_ls_q;

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Sequences the word-addressed memory interface (64-word clocked ROM at 0-63, 64-word RAM at 64-127) and shares it between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Grants one access at a time, drives the memory bus, and waits a fixed access time plus MFC.
- Returns read data or an error to the winning requester with a one-cycle ack pulse.
- Sits between the control unit's fetch/memory stages and the memory interface.

Parameters:
- ACCESS_CYCLES, 2, cycles the bus is held per access (must be >=2 to cover clocked ROM latency).
- TIMEOUT_CYCLES, 16, extra cycles to wait for MEM_MFC after ACCESS_CYCLES before aborting with error.
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is pending before IF is forced.
- ADDR_LIMIT, 127, highest legal word address.
- ROM_TOP, 63, highest ROM word address; writes at or below it are illegal.

Ports:
- MEMARB_Clock  in  1  system clock, rising edge.
- MEMARB_Reset  in  1  synchronous, active-high reset.
- IF_Req  in  1  fetch request; held high with IF_Address stable until IF_Ack.
- IF_Address  in  32  fetch word address.
- IF_Ack  out  1  one-cycle completion pulse.
- IF_Data  out  32  fetched word; valid while IF_Ack=1.
- IF_Error  out  1  access failed; valid while IF_Ack=1.
- LS_Req  in  1  load/store request; held with LS_Address, LS_Write and LS_Data_In stable until LS_Ack.
- LS_Write  in  1  1=store, 0=load.
- LS_Address  in  32  data word address.
- LS_Data_In  in  32  store data.
- LS_Ack  out  1  one-cycle completion pulse.
- LS_Data  out  32  load data; valid while LS_Ack=1.
- LS_Error  out  1  access failed; valid while LS_Ack=1.
- MEM_Address  out  32  to memory interface.
- MEM_Data_In  out  32  to memory interface.
- MEM_r_w_z_z  out  2  00=read, 01=write, 10=high-Z/idle.
- MEM_Data_Out  in  32  from memory interface.
- MEM_MFC  in  1  memory function complete.
- MEM_ERROR  in  1  unmapped-address flag from memory interface.
- MEMARB_Busy  out  1  high in any state other than IDLE.
- MEMARB_Grant_LS  out  1  1 = current or last grant went to LS.

Behaviour:
- Reset values: all acks, errors, data outputs, Busy, Grant_LS and MEM_Address/MEM_Data_In = 0; MEM_r_w_z_z = 10; FSM = IDLE; streak and counters = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE arbitration:
  - LS wins if LS_Req=1, unless IF_Req=1 and streak = MAX_LS_STREAK, in which case IF wins.
  - The winner's request is latched (address, write flag, data).
  - Streak increments on an LS grant while IF_Req=1, and clears on any IF grant or on an LS grant with IF_Req=0.
- Pre-check at grant: error if latched address > ADDR_LIMIT, or if write and address <= ROM_TOP. On error go straight to DONE with error=1, data=0; the bus stays 10 and is never driven.
- Otherwise go to ACCESS. MEM_Address and MEM_Data_In come from the latched values. MEM_r_w_z_z = 00 for read, 01 for write, held for the whole of ACCESS.
- ACCESS completion:
  - The cycle counter runs 1..ACCESS_CYCLES.
  - At or after count ACCESS_CYCLES, the first cycle with MEM_MFC=1 captures MEM_Data_Out (reads) and MEM_ERROR into the result registers, then moves to DONE.
  - If MEM_MFC stays 0 for TIMEOUT_CYCLES after ACCESS_CYCLES, go to DONE with error=1, data=0.
- DONE: bus returns to 10. The granted requester's Ack=1 for exactly one cycle with Data/Error from the result registers. The other requester's Ack stays 0. Next state is IDLE.
- Latency (req seen high in IDLE at cycle T, MFC=1):
  - Ack at T+ACCESS_CYCLES+1 (T+3 by default).
  - Pre-check error: Ack at T+1.
- After its Ack, a requester must drop Req, or present a new request, in the cycle after Ack. IDLE always spends at least one cycle; requests are sampled only in IDLE.
- Write ack: LS_Data = 0, LS_Error = captured MEM_ERROR.
- Simultaneous IF_Req and LS_Req with streak < MAX: LS is granted and IF waits with no ack.
- Reset mid-operation: abort immediately. No ack is issued; the bus returns to 10 in the cycle after reset is sampled, and all state is as at reset.
- Request dropped before ack: protocol violation. The access completes and Ack still pulses.

Test Plan:
- Reset, then IF_Req=1 with IF_Address=5 and memory returning 0xDEADBEEF with MFC=1 -> MEM_r_w_z_z=00 for 2 cycles; IF_Ack pulses at T+3 with IF_Data=0xDEADBEEF, IF_Error=0.
- LS store: LS_Write=1, LS_Address=70, LS_Data_In=0x12345678 -> MEM_r_w_z_z=01 and MEM_Address=70 for 2 cycles; LS_Ack at T+3; a following load from 70 returns 0x12345678.
- Both requesters held high continuously -> grant order LS,LS,LS,LS,IF,LS... and IF_Ack appears after the 4th LS_Ack.
- LS store to address 10 (ROM), then LS load from 200 -> each gives LS_Ack at T+1 with LS_Error=1; MEM_r_w_z_z stays 10 throughout.
- IF read with MEM_MFC held at 0 -> IF_Ack with IF_Error=1 at T+2+16+1; FSM returns to IDLE.
- MEMARB_Reset asserted during ACCESS -> no ack; next cycle MEM_r_w_z_z=10, MEMARB_Busy=0; a new request is served normally.
